// File: rtl/hex_display_scheduler.sv
// +--------------------------------------------------------------------------+
// | hex_display_scheduler: shares one 2-digit 7-seg decoder among channels.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module hex_display_scheduler #(
  parameter int NUM_CH       = 4,
  parameter int CH_W         = 2,
  parameter int DWELL_CYCLES = 50000000,
  parameter int CNT_W        = 26
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [5*NUM_CH-1:0]   ch_data,
  input  logic [NUM_CH-1:0]     ch_valid,
  input  logic                  mode_auto,
  input  logic [CH_W-1:0]       sel_ch,
  input  logic                  hold,
  input  logic                  step,
  output logic [4:0]            disp_value,
  output logic [CH_W-1:0]       disp_ch,
  output logic                  disp_blank,
  output logic                  busy
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ADVANCE = 2'd1;
  localparam logic [1:0] ST_SHOW    = 2'd2;

  localparam logic [CH_W-1:0]  LAST_CH    = CH_W'(NUM_CH - 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic [CH_W-1:0]  idx_q, idx_d;
  logic [CH_W-1:0]  cand_q, cand_d;
  logic [CH_W-1:0]  scan_q, scan_d;
  logic [CNT_W-1:0] dwell_q, dwell_d;
  logic [4:0]       disp_value_q, disp_value_d;
  logic [CH_W-1:0]  disp_ch_q, disp_ch_d;
  logic             disp_blank_q, disp_blank_d;
  logic             busy_q, busy_d;
  logic             auto_q, auto_d;
  logic             step_s1_q, step_s1_d;
  logic             step_s2_q, step_s2_d;
  logic             step_s3_q, step_s3_d;
  logic             step_pulse;

  function automatic logic [CH_W-1:0] wrap_inc(input logic [CH_W-1:0] x);
    logic [CH_W-1:0] r;
    r = (x >= LAST_CH) ? '0 : x + 1'b1;
    return r;
  endfunction

  // Loop-based muxes so an out-of-range index reads as "not valid, zero data".
  function automatic logic valid_at(input logic [CH_W-1:0] i);
    logic r;
    r = 1'b0;
    for (int k = 0; k < NUM_CH; k++)
      if (i == CH_W'(k)) r = ch_valid[k];
    return r;
  endfunction

  function automatic logic [4:0] data_at(input logic [CH_W-1:0] i);
    logic [4:0] r;
    r = '0;
    for (int k = 0; k < NUM_CH; k++)
      if (i == CH_W'(k)) r = ch_data[5*k +: 5];
    return r;
  endfunction

  assign step_pulse = step_s2_q & ~step_s3_q;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cand_d       = cand_q;
    scan_d       = scan_q;
    dwell_d      = dwell_q;
    disp_value_d = disp_value_q;
    disp_ch_d    = disp_ch_q;
    disp_blank_d = disp_blank_q;
    auto_d       = hold ? auto_q : mode_auto;
    step_s1_d    = step;
    step_s2_d    = step_s1_q;
    step_s3_d    = step_s2_q;

    if (hold) begin
      // everything frozen; pulses and valid drops seen now are dropped
    end else if (!mode_auto) begin
      state_d      = ST_SHOW;
      idx_d        = sel_ch;
      dwell_d      = '0;
      disp_ch_d    = sel_ch;
      disp_blank_d = ~valid_at(sel_ch);
      if (valid_at(sel_ch)) disp_value_d = data_at(sel_ch);
    end else if (!auto_q) begin
      state_d = ST_ADVANCE;
      cand_d  = wrap_inc(sel_ch);
      scan_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          disp_blank_d = 1'b1;
          if (|ch_valid) begin
            state_d = ST_ADVANCE;
            cand_d  = wrap_inc(idx_q);
            scan_d  = '0;
          end
        end
        ST_ADVANCE: begin
          if (valid_at(cand_q)) begin
            state_d      = ST_SHOW;
            idx_d        = cand_q;
            dwell_d      = '0;
            disp_value_d = data_at(cand_q);
            disp_ch_d    = cand_q;
            disp_blank_d = 1'b0;
          end else if (scan_q == LAST_CH) begin
            state_d      = ST_IDLE;
            disp_blank_d = 1'b1;
          end else begin
            cand_d = wrap_inc(cand_q);
            scan_d = scan_q + 1'b1;
          end
        end
        ST_SHOW: begin
          disp_value_d = data_at(idx_q);
          disp_ch_d    = idx_q;
          disp_blank_d = 1'b0;
          dwell_d      = dwell_q + 1'b1;
          if (!valid_at(idx_q) || step_pulse || dwell_q == DWELL_LAST) begin
            state_d = ST_ADVANCE;
            cand_d  = wrap_inc(idx_q);
            scan_d  = '0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d = (state_d == ST_ADVANCE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      cand_q       <= '0;
      scan_q       <= '0;
      dwell_q      <= '0;
      disp_value_q <= '0;
      disp_ch_q    <= '0;
      disp_blank_q <= 1'b1;
      busy_q       <= 1'b0;
      auto_q       <= 1'b1;
      step_s1_q    <= 1'b0;
      step_s2_q    <= 1'b0;
      step_s3_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cand_q       <= cand_d;
      scan_q       <= scan_d;
      dwell_q      <= dwell_d;
      disp_value_q <= disp_value_d;
      disp_ch_q    <= disp_ch_d;
      disp_blank_q <= disp_blank_d;
      busy_q       <= busy_d;
      auto_q       <= auto_d;
      step_s1_q    <= step_s1_d;
      step_s2_q    <= step_s2_d;
      step_s3_q    <= step_s3_d;
    end
  end

  assign disp_value = disp_value_q;
  assign disp_ch    = disp_ch_q;
  assign disp_blank = disp_blank_q;
  assign busy       = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_hex_display_scheduler.sv
// +--------------------------------------------------------------------------+
// | tb_hex_display_scheduler: directed bench for hex_display_scheduler.      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_hex_display_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [19:0] ch_data;
  logic [3:0]  ch_valid;
  logic        mode_auto;
  logic [1:0]  sel_ch;
  logic        hold;
  logic        step;
  logic [4:0]  disp_value;
  logic [1:0]  disp_ch;
  logic        disp_blank;
  logic        busy;

  int checks = 0;
  int errors = 0;

  hex_display_scheduler #(
    .NUM_CH(4), .CH_W(2), .DWELL_CYCLES(8), .CNT_W(4)
  ) dut (
    .clk(clk), .rst(rst), .ch_data(ch_data), .ch_valid(ch_valid),
    .mode_auto(mode_auto), .sel_ch(sel_ch), .hold(hold), .step(step),
    .disp_value(disp_value), .disp_ch(disp_ch), .disp_blank(disp_blank),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_value"}, disp_value, 0);
    check({tag, "_ch"}, disp_ch, 0);
    check({tag, "_blank"}, disp_blank, 1);
    check({tag, "_busy"}, busy, 0);
  endtask

  // Entered with ADVANCE just begun; ADVANCE lasts n_adv cycles, then a full
  // 8-cycle dwell on ch, ending with the next ADVANCE just begun.
  task automatic adv_then_show(input int n_adv, input int ch, input int val);
    for (int i = 1; i < n_adv; i++) begin
      tick();
      check("adv_busy", busy, 1);
    end
    tick();
    check("show_ch", disp_ch, ch);
    check("show_value", disp_value, val);
    check("show_blank", disp_blank, 0);
    check("show_busy", busy, 0);
    for (int i = 0; i < 7; i++) begin
      tick();
      check("dwell_ch", disp_ch, ch);
      check("dwell_busy", busy, 0);
    end
    tick();
    check("expire_busy", busy, 1);
  endtask

  initial begin
    rst       = 1'b1;
    ch_data   = {5'd31, 5'd20, 5'd9, 5'd3};
    ch_valid  = 4'b1111;
    mode_auto = 1'b1;
    sel_ch    = 2'd0;
    hold      = 1'b0;
    step      = 1'b0;
    tick();
    tick();
    check_reset_vals("reset");

    // Rotation through all four channels
    rst = 1'b0;
    tick();
    check("start_busy", busy, 1);
    check("start_blank", disp_blank, 1);
    adv_then_show(1, 1, 9);
    adv_then_show(1, 2, 20);
    adv_then_show(1, 3, 31);
    adv_then_show(1, 0, 3);

    // Only ch 0 and ch 2 valid: skipping makes ADVANCE 2 cycles
    ch_valid = 4'b0101;
    adv_then_show(2, 2, 20);
    adv_then_show(2, 0, 3);

    // Drop every valid while showing ch 2
    tick();
    check("adv2_busy", busy, 1);
    tick();
    check("drop_pre_ch", disp_ch, 2);
    tick();
    tick();
    ch_valid = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("drop_adv_busy", busy, 1);
      check("drop_adv_ch", disp_ch, 2);
    end
    tick();
    check("idle_blank", disp_blank, 1);
    check("idle_busy", busy, 0);
    tick();
    check("idle_stay_blank", disp_blank, 1);

    ch_valid = 4'b1000;
    tick();
    check("wake_busy", busy, 1);
    tick();
    check("wake_ch", disp_ch, 3);
    check("wake_value", disp_value, 31);
    check("wake_blank", disp_blank, 0);

    // Step pulse while showing ch 0 at dwell 2
    ch_valid = 4'b1111;
    repeat (7) tick();
    tick();
    check("to0_busy", busy, 1);
    tick();
    check("to0_ch", disp_ch, 0);
    tick();
    tick();
    step = 1'b1;
    tick();
    check("step_e1_ch", disp_ch, 0);
    tick();
    check("step_e2_busy", busy, 0);
    tick();
    check("step_e3_busy", busy, 1);
    tick();
    check("step_ch", disp_ch, 1);
    check("step_value", disp_value, 9);
    step = 1'b0;

    // Hold: frozen display, step during hold is lost, dwell resumes
    hold = 1'b1;
    ch_data[9:5] = 5'd12;
    for (int i = 0; i < 20; i++) begin
      if (i == 3) step = 1'b1;
      if (i == 9) step = 1'b0;
      tick();
      check("hold_ch", disp_ch, 1);
      check("hold_value", disp_value, 9);
      check("hold_busy", busy, 0);
    end
    hold = 1'b0;
    tick();
    check("unhold_value", disp_value, 12);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("unhold_ch", disp_ch, 1);
      check("unhold_busy", busy, 0);
    end
    tick();
    check("unhold_expire", busy, 1);
    tick();
    check("after_hold_ch", disp_ch, 2);
    ch_data[9:5] = 5'd9;

    // Manual mode
    mode_auto = 1'b0;
    sel_ch    = 2'd3;
    ch_data[19:15] = 5'd17;
    tick();
    check("man_value", disp_value, 17);
    check("man_ch", disp_ch, 3);
    check("man_blank", disp_blank, 0);
    check("man_busy", busy, 0);
    ch_valid = 4'b0111;
    tick();
    check("man_invalid_blank", disp_blank, 1);
    check("man_invalid_value", disp_value, 17);
    mode_auto = 1'b1;
    tick();
    check("m2a_busy", busy, 1);
    tick();
    check("m2a_ch", disp_ch, 0);
    check("m2a_value", disp_value, 3);
    check("m2a_blank", disp_blank, 0);

    // Asynchronous reset mid-ADVANCE
    repeat (7) tick();
    tick();
    check("pre_rst_busy", busy, 1);
    #3 rst = 1'b1;
    #1 check_reset_vals("rst_adv");
    tick();
    rst = 1'b0;
    tick();
    check("restart1_busy", busy, 1);
    tick();
    check("restart1_ch", disp_ch, 1);
    check("restart1_value", disp_value, 9);

    // Asynchronous reset at dwell 5
    repeat (5) tick();
    check("pre_rst2_ch", disp_ch, 1);
    #3 rst = 1'b1;
    #1 check_reset_vals("rst_dwell");
    tick();
    rst = 1'b0;
    tick();
    check("restart2_busy", busy, 1);
    tick();
    check("restart2_ch", disp_ch, 1);
    check("restart2_blank", disp_blank, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
